// File: rtl/dmem_responder.sv
// Word-organised data RAM slave with a valid/ready request/response handshake and WAIT_CYCLES stall.
// Optional DMEM_ERR_EN flags misaligned or out-of-range addresses through rsp_err.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                commit;

  logic                lat_write;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wdata;
  logic [3:0]          lat_be;
  logic                lat_err;

  logic                cur_write;
  logic [ADDR_W-1:0]   cur_idx;
  logic [31:0]         cur_wdata;
  logic [3:0]          cur_be;
  logic                cur_err;
  logic                req_err;

  logic [31:0]         mem [2**ADDR_W];

`ifdef DMEM_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
`else
  logic unused_addr;
  assign req_err     = 1'b0;
  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // With WAIT_CYCLES = 0 the commit edge is the accept edge, so the live request is used.
  always_comb begin
    cur_write = (state == IDLE) ? req_write : lat_write;
    cur_idx   = (state == IDLE) ? req_addr[ADDR_W+1:2] : lat_idx;
    cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    cur_be    = (state == IDLE) ? req_be : lat_be;
    cur_err   = (state == IDLE) ? req_err : lat_err;
  end

  // Counter is loaded with WAIT_CYCLES so the response appears WAIT_CYCLES+1 edges after accept.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
            commit  = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (commit) begin
        rsp_rdata <= (cur_write || cur_err) ? '0 : mem[cur_idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
      end
    end
  end

`ifdef DMEM_ERR_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_err <= 1'b0;
    end else if (commit) begin
      rsp_err <= cur_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset_n && state == IDLE && req_valid) begin
      lat_write <= req_write;
      lat_idx   <= req_addr[ADDR_W+1:2];
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
      lat_err   <= req_err;
    end
  end

  // Memory has no reset; a store dropped by reset never reaches its commit edge.
  always_ff @(posedge clock) begin
    if (reset_n && commit && cur_write && !cur_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=2, ADDR_W=8; expectations follow DMEM_ERR_EN.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request, optionally stall the response for `hold` cycles while
  // presenting a competing store, then take the response.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                     input int hold, input string tag);
    int lat;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    step();
    check({tag, "_accepted"}, {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      lat++;
      if (rsp_valid) break;
    end
    check({tag, "_latency"}, lat, 32'd3);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      step();
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_done_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_done_err"}, {31'd0, rsp_err}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("por_ready", {31'd0, req_ready}, 32'd1);
    check("por_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset held for two edges during an in-flight load.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    step(); step(); step();
    check("rst_no_late_rsp", {31'd0, rsp_valid}, 32'd0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0, "st_full");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "ld_full");
    txn(1'b1, 32'h10, 32'h00000011, 4'b0001, 32'h0, 1'b0, 0, "st_b0");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE11, 1'b0, 0, "ld_b0");
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0, "st_be0");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE11, 1'b0, 0, "ld_be0");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE11, 1'b0, 3, "ld_bp");
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBE11, 1'b0, 0, "ld_after_bp");

    txn(1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, 0, "st_w0");
`ifdef DMEM_ERR_EN
    txn(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0, "ld_misalign");
    txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 0, "st_range");
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0, 0, "ld_w0");
`else
    txn(1'b0, 32'h13, 32'h0, 4'h0, 32'hDEADBE11, 1'b0, 0, "ld_misalign");
    txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0, "st_wrap");
    txn(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, "ld_w0");
`endif

    // Store dropped by reset in WAIT must leave the old word intact.
    txn(1'b1, 32'h20, 32'hAAAA5555, 4'hF, 32'h0, 1'b0, 0, "st_w8");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    step();
    check("midwait_accepted", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("midwait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'hAAAA5555, 1'b0, 0, "ld_w8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
